// File: rtl/tile_mv_seq_if.sv
// Operand/result handshake bundle for tile_mv_seq: valid/ready on both sides,
// captured operands in, held result plus status out.
interface tile_mv_seq_if #(
    parameter int VEC_LEN  = 4,
    parameter int MAT_R    = 4,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_BITS-1:0]  in_vec [VEC_LEN];
    logic signed [IN_BITS-1:0]  mat [MAT_R][VEC_LEN];
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_BITS-1:0] out_vec [MAT_R];
    logic                       sat_flag;
    logic                       busy;

    modport master (
        output in_valid, in_vec, mat, out_ready,
        input  in_ready, out_valid, out_vec, sat_flag, busy
    );

    modport slave (
        input  in_valid, in_vec, mat, out_ready,
        output in_ready, out_valid, out_vec, sat_flag, busy
    );
endinterface

// File: rtl/tile_mv_seq.sv
// Time-multiplexed matrix-vector tile: LANES dot products per cycle, saturated to OUT_BITS.
// Optional macro TILE_RELU_EN forces negative saturated results to zero.
module tile_mv_seq #(
    parameter int VEC_LEN  = 4,
    parameter int MAT_R    = 4,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8,
    parameter int LANES    = 2
) (
    input logic         clock,
    input logic         reset,
    tile_mv_seq_if.slave bus
);
    localparam int ACC_BITS  = 2*IN_BITS + $clog2(VEC_LEN);
    localparam int PROD_BITS = 2*IN_BITS;
    localparam int CMP_BITS  = ACC_BITS + OUT_BITS;
    localparam int RW        = (MAT_R > 1) ? $clog2(MAT_R) : 1;
    localparam logic [RW:0] LANE_STEP = (RW+1)'(LANES);
    localparam logic [RW:0] LAST_ROW  = (RW+1)'(MAT_R);
    localparam logic signed [CMP_BITS-1:0] SAT_MAX =
        {{(CMP_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [CMP_BITS-1:0] SAT_MIN =
        {{(CMP_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
    localparam logic signed [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    generate
        if (MAT_R % LANES != 0) begin : g_lanes_check
            $error("tile_mv_seq: MAT_R must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state, state_next;

    logic signed [IN_BITS-1:0]  vec_q [VEC_LEN];
    logic signed [IN_BITS-1:0]  mat_q [MAT_R][VEC_LEN];
    logic signed [OUT_BITS-1:0] shadow_q [MAT_R];
    logic signed [OUT_BITS-1:0] out_vec_q [MAT_R];
    logic [RW:0]                row_idx;
    logic                       sat_acc;
    logic                       sat_flag_q;
    logic                       in_ready, out_valid, busy;

    logic [RW:0]                lane_row  [LANES];
    logic signed [ACC_BITS-1:0] lane_acc  [LANES];
    logic signed [CMP_BITS-1:0] lane_wide [LANES];
    logic signed [OUT_BITS-1:0] lane_val  [LANES];
    logic [LANES-1:0]           lane_sat;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_next = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (row_idx >= LAST_ROW) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulation is wide enough to never overflow; clamping happens only at the end.
    always_comb begin
        lane_sat = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_row[k] = row_idx + (RW+1)'(k);
            lane_acc[k] = '0;
            if (lane_row[k] < LAST_ROW) begin
                for (int c = 0; c < VEC_LEN; c++) begin
                    lane_acc[k] = lane_acc[k] + ACC_BITS'(PROD_BITS'(vec_q[c]) *
                                  PROD_BITS'(mat_q[lane_row[k][RW-1:0]][c]));
                end
            end
            lane_wide[k] = CMP_BITS'(lane_acc[k]);
            if (lane_wide[k] > SAT_MAX) begin
                lane_val[k] = OUT_MAX;
                lane_sat[k] = 1'b1;
            end else if (lane_wide[k] < SAT_MIN) begin
                lane_val[k] = OUT_MIN;
                lane_sat[k] = 1'b1;
            end else begin
                lane_val[k] = lane_wide[k][OUT_BITS-1:0];
            end
`ifdef TILE_RELU_EN
            if (lane_val[k][OUT_BITS-1]) lane_val[k] = '0;
`endif
        end
    end

    // One extra COMPUTE cycle after the last row publishes the shadow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_idx    <= '0;
            sat_acc    <= 1'b0;
            sat_flag_q <= 1'b0;
            for (int r = 0; r < MAT_R; r++) begin
                out_vec_q[r] <= '0;
                shadow_q[r]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_q   <= bus.in_vec;
                        mat_q   <= bus.mat;
                        row_idx <= '0;
                        sat_acc <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (row_idx < LAST_ROW) begin
                        for (int k = 0; k < LANES; k++) begin
                            shadow_q[lane_row[k][RW-1:0]] <= lane_val[k];
                        end
                        sat_acc <= sat_acc | (|lane_sat);
                        row_idx <= row_idx + LANE_STEP;
                    end else begin
                        out_vec_q  <= shadow_q;
                        sat_flag_q <= sat_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_vec   = out_vec_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_tile_mv_seq.sv
// Bench for tile_mv_seq: LANES=2 and LANES=4 instances share stimulus and are
// checked every cycle against a job-timeline model of the matrix-vector product.
module tb_tile_mv_seq;
    localparam int N = 4;
    localparam int PHASES [2] = '{2, 1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [3:0] in_vec [N];
    logic signed [3:0] mat [N][N];
    logic signed [3:0] job_vec [N];
    logic signed [3:0] job_mat [N][N];

    int passed = 0;
    int total = 0;

    always #5 clock = ~clock;

    tile_mv_seq_if #(.VEC_LEN(N), .MAT_R(N), .IN_BITS(4), .OUT_BITS(8)) bus_a ();
    tile_mv_seq_if #(.VEC_LEN(N), .MAT_R(N), .IN_BITS(4), .OUT_BITS(8)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.out_ready = out_ready;
    assign bus_a.in_vec    = in_vec;
    assign bus_a.mat       = mat;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.out_ready = out_ready;
    assign bus_b.in_vec    = in_vec;
    assign bus_b.mat       = mat;

    tile_mv_seq #(.VEC_LEN(N), .MAT_R(N), .IN_BITS(4), .OUT_BITS(8), .LANES(2)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a));
    tile_mv_seq #(.VEC_LEN(N), .MAT_R(N), .IN_BITS(4), .OUT_BITS(8), .LANES(4)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b));

    // Model: a job is accepted when idle, publishes P+1 edges later, retires on out_ready.
    int m_act [2] = '{0, 0};
    int m_vld [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int m_out [2][N];
    int m_sat [2] = '{0, 0};
    int p_out [2][N];
    int p_sat [2] = '{0, 0};

    initial begin
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < N; r++) begin
                m_out[i][r] = 0;
                p_out[i][r] = 0;
            end
    end

    task automatic model_job(input int i);
        int s;
        p_sat[i] = 0;
        for (int r = 0; r < N; r++) begin
            s = 0;
            for (int c = 0; c < N; c++) s += int'(in_vec[c]) * int'(mat[r][c]);
            if (s > 127) begin s = 127; p_sat[i] = 1; end
            else if (s < -128) begin s = -128; p_sat[i] = 1; end
`ifdef TILE_RELU_EN
            if (s < 0) s = 0;
`endif
            p_out[i][r] = s;
        end
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0;
                m_vld[i] = 0;
                m_sat[i] = 0;
                for (int r = 0; r < N; r++) m_out[i][r] = 0;
            end else if (m_vld[i] != 0) begin
                if (out_ready) begin
                    m_vld[i] = 0;
                    m_act[i] = 0;
                end
            end else if (m_act[i] != 0) begin
                m_cnt[i]++;
                if (m_cnt[i] == PHASES[i] + 1) begin
                    m_vld[i] = 1;
                    m_sat[i] = p_sat[i];
                    for (int r = 0; r < N; r++) m_out[i][r] = p_out[i][r];
                end
            end else if (in_valid) begin
                m_act[i] = 1;
                m_cnt[i] = 0;
                model_job(i);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic check_inst(input int i, input logic ir, input logic ov, input logic bz,
                              input logic sf, input logic signed [7:0] vec [N]);
        checkOutput($sformatf("dut%0d in_ready", i), int'(ir), (m_act[i] != 0) ? 0 : 1);
        checkOutput($sformatf("dut%0d busy", i), int'(bz), (m_act[i] != 0) ? 1 : 0);
        checkOutput($sformatf("dut%0d out_valid", i), int'(ov), m_vld[i]);
        checkOutput($sformatf("dut%0d sat_flag", i), int'(sf), m_sat[i]);
        for (int r = 0; r < N; r++)
            checkOutput($sformatf("dut%0d out_vec[%0d]", i, r), int'(vec[r]), m_out[i][r]);
    endtask

    always @(negedge clock) begin
        check_inst(0, bus_a.in_ready, bus_a.out_valid, bus_a.busy, bus_a.sat_flag, bus_a.out_vec);
        check_inst(1, bus_b.in_ready, bus_b.out_valid, bus_b.busy, bus_b.sat_flag, bus_b.out_vec);
    end

    function automatic logic signed [3:0] rand_nib();
        logic [31:0] r;
        r = $urandom;
        return r[3:0];
    endfunction

    task automatic scramble();
        for (int r = 0; r < N; r++) begin
            in_vec[r] = rand_nib();
            for (int c = 0; c < N; c++) mat[r][c] = rand_nib();
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && (m_act[0] != 0 || m_act[1] != 0); n++) @(negedge clock);
        if (m_act[0] != 0 || m_act[1] != 0) checkOutput("idle timeout", 1, 0);
    endtask

    task automatic set_identity(input int v0, input int v1, input int v2, input int v3);
        job_vec[0] = 4'(v0); job_vec[1] = 4'(v1); job_vec[2] = 4'(v2); job_vec[3] = 4'(v3);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) job_mat[r][c] = (r == c) ? 4'sd1 : 4'sd0;
    endtask

    // Present one job for exactly one edge, then disturb the operands.
    task automatic applyStimulus();
        wait_idle();
        in_vec   = job_vec;
        mat      = job_mat;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic check_literal(input string tag, input int e0, input int e1, input int e2,
                                 input int e3, input int esat);
        int e [N];
        e = '{e0, e1, e2, e3};
        for (int r = 0; r < N; r++) begin
            checkOutput($sformatf("%s a[%0d]", tag, r), int'(bus_a.out_vec[r]), e[r]);
            checkOutput($sformatf("%s b[%0d]", tag, r), int'(bus_b.out_vec[r]), e[r]);
        end
        checkOutput($sformatf("%s a sat", tag), int'(bus_a.sat_flag), esat);
        checkOutput($sformatf("%s b sat", tag), int'(bus_b.sat_flag), esat);
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            in_vec[r] = '0;
            for (int c = 0; c < N; c++) mat[r][c] = '0;
        end
        repeat (2) @(negedge clock);
        checkOutput("reset a in_ready", int'(bus_a.in_ready), 1);
        checkOutput("reset a out_vec[0]", int'(bus_a.out_vec[0]), 0);
        reset = 1'b0;

        // Basic identity job with exact latency per lane count
        set_identity(1, 2, 3, 4);
        applyStimulus();
        for (int e = 0; e < 4; e++) begin
            if (e > 0) @(negedge clock);
            checkOutput($sformatf("latency a edge%0d", e), int'(bus_a.out_valid), (e == 3) ? 1 : 0);
            checkOutput($sformatf("latency b edge%0d", e), int'(bus_b.out_valid), (e == 2) ? 1 : 0);
            if (e < 2) checkOutput("basic a in_ready", int'(bus_a.in_ready), 0);
        end
        wait_idle();
        check_literal("basic", 1, 2, 3, 4, 0);

        // Positive saturation, then a clean job clears the flag
        for (int r = 0; r < N; r++) begin
            job_vec[r] = -4'sd8;
            for (int c = 0; c < N; c++) job_mat[r][c] = -4'sd8;
        end
        applyStimulus();
        wait_idle();
        check_literal("saturate", 127, 127, 127, 127, 1);
        set_identity(1, 2, 3, 4);
        applyStimulus();
        wait_idle();
        check_literal("unsat", 1, 2, 3, 4, 0);

        // Negative results
        for (int r = 0; r < N; r++) begin
            job_vec[r] = 4'sd1;
            for (int c = 0; c < N; c++)
                job_mat[r][c] = (r == 0) ? -4'sd1 : ((c == 0) ? 4'sd2 : 4'sd0);
        end
        applyStimulus();
        wait_idle();
`ifdef TILE_RELU_EN
        check_literal("negative", 0, 2, 2, 2, 0);
`else
        check_literal("negative", -4, 2, 2, 2, 0);
`endif

        // All-ones rows; operands disturbed after accept
        for (int r = 0; r < N; r++) begin
            job_vec[r] = 4'(r + 1);
            for (int c = 0; c < N; c++) job_mat[r][c] = 4'sd1;
        end
        applyStimulus();
        wait_idle();
        check_literal("ones", 10, 10, 10, 10, 0);

        // Backpressure: results hold, extra in_valid ignored
        out_ready = 1'b0;
        set_identity(-3, 5, -7, 6);
        applyStimulus();
        for (int n = 0; n < 20 && m_vld[0] == 0; n++) @(negedge clock);
        checkOutput("bp a valid", int'(bus_a.out_valid), 1);
        for (int n = 0; n < 5; n++) begin
            scramble();
            in_valid = 1'b1;
            @(negedge clock);
            checkOutput("bp a in_ready", int'(bus_a.in_ready), 0);
            checkOutput("bp b in_ready", int'(bus_b.in_ready), 0);
        end
        in_valid = 1'b0;
        check_literal("bp hold", -3, 5, -7, 6, 0);
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("bp release a", int'(bus_a.in_ready), 1);
        checkOutput("bp release b", int'(bus_b.in_ready), 1);

        // Reset one cycle into COMPUTE discards the job
        set_identity(3, 3, 3, 3);
        applyStimulus();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst a out_valid", int'(bus_a.out_valid), 0);
        checkOutput("rst a in_ready", int'(bus_a.in_ready), 1);
        checkOutput("rst a busy", int'(bus_a.busy), 0);
        check_literal("rst", 0, 0, 0, 0, 0);
        set_identity(2, -3, 4, -5);
        applyStimulus();
        wait_idle();
        check_literal("post rst", 2, -3, 4, -5, 0);

        // Randomized jobs with random backpressure and stray in_valid
        for (int j = 0; j < 40; j++) begin
            for (int r = 0; r < N; r++) begin
                job_vec[r] = ($urandom_range(0, 4) == 0) ? -4'sd8 : rand_nib();
                for (int c = 0; c < N; c++)
                    job_mat[r][c] = ($urandom_range(0, 4) == 0) ? 4'sd7 : rand_nib();
            end
            applyStimulus();
            for (int n = 0; n < 12; n++) begin
                out_ready = ($urandom_range(0, 1) == 1);
                in_valid  = ($urandom_range(0, 3) == 0);
                scramble();
                @(negedge clock);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            wait_idle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
